// File: rtl/hand_total_pkg.sv
// Shared types and constants for the hand-total BCD converter.
// Optional feature macro used by the top: HAND_TOTAL_DIGITS_LEADING_BLANK_EN.
package hand_total_pkg;

   localparam int         DIGIT_W     = 4;
   localparam logic [3:0] DIGIT_BLANK = 4'hF;

   typedef enum logic [1:0] {
      HT_IDLE,
      HT_SHIFT,
      HT_DONE
   } ht_state_t;

   // Constant 10^n, used to check at elaboration that NDIG digits can hold any W-bit value.
   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/hand_total_digits_bcd_add3.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3
   import hand_total_pkg::*;
(
   input  logic [DIGIT_W-1:0] nib_in,
   output logic [DIGIT_W-1:0] nib_out
);

   // Add-3 correction, confined to this nibble.
   always_comb begin
      nib_out = (nib_in >= DIGIT_W'(5)) ? nib_in + DIGIT_W'(3) : nib_in;
   end

endmodule

// File: rtl/hand_total_digits.sv
// Sequential binary-to-BCD converter (shift-and-add-3) for the score display.
// start/busy/done handshake; W shift iterations, one DONE cycle, then IDLE.
// Define HAND_TOTAL_DIGITS_LEADING_BLANK_EN to blank leading zero digits (4'hF).
module hand_total_digits
   import hand_total_pkg::*;
#(
   parameter int W    = 8,
   parameter int NDIG = 3
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [W-1:0]            value,
   output logic                    busy,
   output logic                    done,
   output logic [DIGIT_W*NDIG-1:0] digits
);

   localparam int BCD_W = DIGIT_W * NDIG;
   localparam int CNT_W = $clog2(W + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

   if (((64'd1 << W) - 64'd1) > (pow10(NDIG) - 64'd1)) begin : g_cfg_illegal
      $error("hand_total_digits: NDIG too small for W");
   end

   ht_state_t         state_q, state_d;
   logic [W-1:0]      bin_q, bin_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;
   logic [BCD_W-1:0]  bcd_adj;
   logic [BCD_W-1:0]  disp_bcd;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BCD_W-1:0]  digits_q, digits_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   for (genvar g = 0; g < NDIG; g++) begin : g_add3
      bcd_add3 u_add3 (
         .nib_in  (bcd_q[g*DIGIT_W +: DIGIT_W]),
         .nib_out (bcd_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= HT_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: IDLE -> SHIFT on start, SHIFT for W cycles, one DONE cycle.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HT_IDLE:  if (start) state_d = HT_SHIFT;
         HT_SHIFT: if (cnt_q == LAST_ITER) state_d = HT_DONE;
         HT_DONE:  state_d = HT_IDLE;
         default:  state_d = HT_IDLE;
      endcase
   end

   // Registered handshake outputs, decoded from the upcoming state.
   always_comb begin
      busy_d = (state_d != HT_IDLE);
      done_d = (state_d == HT_DONE);
   end

   // Display form of the finished accumulator.
`ifdef HAND_TOTAL_DIGITS_LEADING_BLANK_EN
   always_comb begin
      logic leading;
      disp_bcd = bcd_q;
      leading  = 1'b1;
      // The ones digit is excluded so a zero total still shows "0".
      for (int i = NDIG - 1; i >= 1; i--) begin
         if (leading && (bcd_q[i*DIGIT_W +: DIGIT_W] == '0)) begin
            disp_bcd[i*DIGIT_W +: DIGIT_W] = DIGIT_BLANK;
         end else begin
            leading = 1'b0;
         end
      end
   end
`else
   always_comb begin
      disp_bcd = bcd_q;
   end
`endif

   // Datapath: load on start, add-3 then shift each SHIFT cycle, publish digits in DONE.
   always_comb begin
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      digits_d = digits_q;
      unique case (state_q)
         HT_IDLE: begin
            if (start) begin
               bin_d = value;
               bcd_d = '0;
               cnt_d = '0;
            end
         end
         HT_SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q + CNT_W'(1);
         end
         HT_DONE: begin
            digits_d = disp_bcd;
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   // NOTE: the shift registers are reset too, so an aborted conversion leaves no stale state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         digits_q <= {NDIG{DIGIT_BLANK}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         digits_q <= digits_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign digits = digits_q;

endmodule

// File: tb/tb_hand_total_digits.sv
// Self-checking bench for hand_total_digits (W=8, NDIG=3).
// Honours HAND_TOTAL_DIGITS_LEADING_BLANK_EN the same way the design does.
module tb_hand_total_digits;

   localparam int W    = 8;
   localparam int NDIG = 3;
   localparam int DW   = 4 * NDIG;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  value;
   logic          busy;
   logic          done;
   logic [DW-1:0] digits;

   int n_vec  = 0;
   int n_fail = 0;

   logic [DW-1:0] sb_q[$];

   typedef struct {
      logic [W-1:0]  value;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t tbl[10];

   hand_total_digits #(.W(W), .NDIG(NDIG)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .value  (value),
      .busy   (busy),
      .done   (done),
      .digits (digits)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: decimal digits by division, with optional leading-zero blanking.
   function automatic logic [DW-1:0] model(input int v);
      logic [3:0] d2, d1, d0;
      d2 = 4'(v / 100);
      d1 = 4'((v / 10) % 10);
      d0 = 4'(v % 10);
`ifdef HAND_TOTAL_DIGITS_LEADING_BLANK_EN
      if (d2 == 4'd0) begin
         d2 = 4'hF;
         if (d1 == 4'd0) d1 = 4'hF;
      end
`endif
      return {d2, d1, d0};
   endfunction

   task automatic check_digits(input string name);
      logic [DW-1:0] e;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL %s: got %0h expected <empty scoreboard>", name, digits);
      end else begin
         e = sb_q.pop_front();
         check(name, 32'(digits), 32'(e));
      end
   endtask

   // Called at the negedge of cycle 1; returns the cycle index where done is seen.
   task automatic wait_done(output int n);
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   // One full conversion with latency and handshake checks.
   task automatic convert(input logic [W-1:0] v, input logic [DW-1:0] e);
      int n;
      @(negedge clk);
      start = 1'b1;
      value = v;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      value = W'($urandom);
      wait_done(n);
      check("latency", n, W + 1);
      check("busy_in_done", busy, 1);
      @(negedge clk);
      check("busy_after", busy, 0);
      check("done_after", done, 0);
      check_digits("digits");
   endtask

   initial begin
      int n;
      int done_cnt;
      int done_at;

`ifdef HAND_TOTAL_DIGITS_LEADING_BLANK_EN
      tbl[0] = '{8'd21,  12'hF21};
      tbl[1] = '{8'd0,   12'hFF0};
      tbl[2] = '{8'd255, 12'h255};
      tbl[3] = '{8'd9,   12'hFF9};
      tbl[4] = '{8'd10,  12'hF10};
      tbl[5] = '{8'd99,  12'hF99};
      tbl[6] = '{8'd100, 12'h100};
      tbl[7] = '{8'd200, 12'h200};
      tbl[8] = '{8'd105, 12'h105};
      tbl[9] = '{8'd7,   12'hFF7};
`else
      tbl[0] = '{8'd21,  12'h021};
      tbl[1] = '{8'd0,   12'h000};
      tbl[2] = '{8'd255, 12'h255};
      tbl[3] = '{8'd9,   12'h009};
      tbl[4] = '{8'd10,  12'h010};
      tbl[5] = '{8'd99,  12'h099};
      tbl[6] = '{8'd100, 12'h100};
      tbl[7] = '{8'd200, 12'h200};
      tbl[8] = '{8'd105, 12'h105};
      tbl[9] = '{8'd7,   12'h007};
`endif

      rst   = 1'b1;
      start = 1'b0;
      value = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_digits", 32'(digits), 32'hFFF);
      rst = 1'b0;

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         convert(tbl[i].value, tbl[i].exp);
      end

      // Exhaustive sweep against the model.
      for (int v = 0; v < 256; v++) begin
         convert(W'(v), model(v));
      end

      // start held through the conversion, value changed mid-SHIFT.
      @(negedge clk);
      start = 1'b1;
      value = 8'd21;
      sb_q.push_back(model(21));
      done_cnt = 0;
      done_at  = 0;
      for (int cyc = 1; cyc <= 22; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            done_at = cyc;
         end
         if (cyc == 3) value = 8'd77;
         if (cyc == 9) check("held_done1", done, 1);
         if (cyc == 10) begin
            check("held_busy_idle", busy, 0);
            check_digits("held_digits1");
            sb_q.push_back(model(77));
         end
         if (cyc == 11) check("held_busy_restart", busy, 1);
         if (cyc == 19) start = 1'b0;
         if (cyc == 20) check_digits("held_digits2");
         if (cyc == 22) check("held_busy_end", busy, 0);
      end
      check("held_done_count", done_cnt, 2);
      check("held_done2_cycle", done_at, 19);

      // start only in the DONE cycle is ignored.
      @(negedge clk);
      start = 1'b1;
      value = 8'd33;
      sb_q.push_back(model(33));
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      check("b2b_latency", n, W + 1);
      start = 1'b1;
      value = 8'd44;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy_idle", busy, 0);
      check_digits("b2b_digits_a");
      done_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (busy === 1'b1 || done === 1'b1) done_cnt++;
      end
      check("b2b_ignored", done_cnt, 0);

      // start in DONE held into IDLE is accepted.
      @(negedge clk);
      start = 1'b1;
      value = 8'd60;
      sb_q.push_back(model(60));
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      check("b2b_latency2", n, W + 1);
      start = 1'b1;
      value = 8'd61;
      sb_q.push_back(model(61));
      @(negedge clk);
      check("b2b_busy_idle2", busy, 0);
      check_digits("b2b_digits_b");
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy_accept", busy, 1);
      wait_done(n);
      check("b2b_latency3", n, W + 1);
      @(negedge clk);
      check_digits("b2b_digits_c");

      // Async reset in cycle 4 of a conversion.
      @(negedge clk);
      start = 1'b1;
      value = 8'd123;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_digits", 32'(digits), 32'hFFF);
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_cnt++;
      end
      check("abort_no_done", done_cnt, 0);
      check("abort_digits_held", 32'(digits), 32'hFFF);
      convert(8'd123, model(123));

      check("scoreboard_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/hand_total_digits.md
# hand_total_digits

Sequential binary-to-BCD converter that turns a hand total (player or dealer score) into per-digit 4-bit codes for the seven-segment display driver. It uses an iterative shift-and-add-3 (double-dabble) algorithm and a start/busy/done handshake. It sits between the game FSM, which produces binary totals, and the display driver, which consumes digit codes 0–9 and shows any code 4'hF as blank.

## Interface
- `W`, default 8: input value width in bits.
- `NDIG`, default 3: number of output digits. Elaboration is illegal unless 2^W−1 ≤ 10^NDIG−1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a conversion; `value` is sampled in the same cycle.
- `value`  in  W  unsigned binary total.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when `digits` has been updated.
- `digits`  out  4*NDIG  digit codes; [3:0] is the ones digit and [4*NDIG-1:4*NDIG-4] is the most significant digit.

## Operation
- **Reset values:** state IDLE, `busy`=0, `done`=0, every `digits` nibble = 4'hF (blank).
- **States:** IDLE → SHIFT → DONE → IDLE.
- **IDLE:**
  - If `start`=1: capture `value` into the binary shift register, clear the BCD accumulator, clear the iteration counter, go to SHIFT.
  - If `start`=0: stay in IDLE.
- **SHIFT:** runs exactly W iterations. Each iteration:
  - Add 3 to every BCD nibble that is ≥5.
  - Shift the concatenation {BCD, binary} left by 1.
  - Increment the counter.
  - After iteration W, go to DONE.
- **DONE:**
  - Load `digits` from the BCD accumulator, applying blanking if configured.
  - Pulse `done` for this one cycle.
  - Return to IDLE.
- `start` is ignored in SHIFT and DONE. There is no queueing, and `value` changes during SHIFT have no effect.
- `digits` holds its last value until the next DONE. It never shows intermediate accumulator contents.
- **Width rules:**
  - The accumulator is 4*NDIG bits and the counter is $clog2(W+1) bits.
  - Add-3 is applied only to nibbles, never across nibble boundaries.
  - Every nibble is guaranteed ≤9 at DONE.
- **Reset mid-operation:** returns immediately to the reset values. No `done` is produced for the aborted conversion.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..W: SHIFT; `busy`=1.
- Cycle W+1: DONE; `busy`=1, `done`=1, and `digits` holds the new value from the end of this cycle.
- Cycle W+2: IDLE; `busy`=0. A new `start` is accepted at the earliest here.
- Total latency from `start` to `done` is W+1 cycles (9 at the default W). Throughput is one conversion per W+2 cycles.
- `done` and `busy` are registered outputs with no combinational path from the inputs. `digits` is registered.

## Configuration
- Macro: `HAND_TOTAL_DIGITS_LEADING_BLANK_EN`.
- **Defined:**
  - At DONE, each leading zero nibble, scanning from the most significant digit down, is replaced by 4'hF.
  - The ones digit is never blanked, so value 0 displays as a single "0".
  - No added latency.
- **Undefined:** all NDIG nibbles are loaded as plain BCD digits 0–9, with leading zeros shown.
- Reset value (all 4'hF) is identical in both builds.

## Structure
- Shared package `hand_total_pkg` contains:
  - `DIGIT_BLANK` = 4'hF.
  - State enum `ht_state_t` {HT_IDLE, HT_SHIFT, HT_DONE}.
  - `DIGIT_W` = 4.
- Sub-module `bcd_add3`: combinational 4-bit nibble correction (in ≥5 → in+3, else in). It is instantiated NDIG times in a generate loop.
- All remaining logic (FSM, counter, shift registers, blanking) lives in the top module.

## Test plan
- **Value 21, macro defined:** `start` pulse → `done` at cycle 9, `digits` = {F,2,1}, `busy` low at cycle 10.
- **Value 21, macro undefined:** same timing → `digits` = {0,2,1}.
- **Values 0 and 255, macro defined:**
  - 0 → {F,F,0}.
  - 255 → {2,5,5}.
  - Exhaustively sweep 0–255 against a reference model.
- **`start` held high through a whole conversion, with `value` changed mid-SHIFT:** result reflects only the value sampled at cycle 0. A second conversion starts only at the cycle after `busy` falls, and `done` pulses once per conversion.
- **Async `rst` asserted at cycle 4 of a conversion:** `busy`=0, `done`=0 and `digits`=all F immediately. No `done` follows. A new `start` after release converts correctly.
- **Back-to-back:** `start` asserted in the DONE cycle is ignored. The same request held into the following IDLE cycle is accepted and completes W+1 cycles later.
